// File: rtl/sensor_conditioner.sv
// Per-channel sync + debounce conditioner: clean level plus one-cycle rise/fall strobes; optional sticky rise latch (SENSOR_LATCH_EN).
// Latency: raw first sampled at edge k -> clean/strobe registered after edge k+DEB_CYCLES+1; any_active is combinational from clean.
// Backpressure: none; ena=0 freezes FSMs/counters and clears strobes, synchronisers keep running.
module sensor_conditioner #(
    parameter int N_CH       = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N_CH-1:0] sensor_raw,
    input  logic [N_CH-1:0] clr_latch,
    output logic [N_CH-1:0] sensor_clean,
    output logic [N_CH-1:0] sensor_rise,
    output logic [N_CH-1:0] sensor_fall,
    output logic            any_active,
    output logic [N_CH-1:0] evt_latch
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, QUAL, ACTIVE, REL} state_t;

    state_t          state_q [N_CH];
    state_t          state_d [N_CH];
    logic [CW-1:0]   cnt_q   [N_CH];
    logic [CW-1:0]   cnt_d   [N_CH];
    logic [N_CH-1:0] s1_q, s_q;
    logic [N_CH-1:0] clean_q, clean_d;
    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;

    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (ena) begin
                case (state_q[i])
                    IDLE: begin
                        if (s_q[i]) begin
                            state_d[i] = QUAL;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                    QUAL: begin
                        if (!s_q[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = ACTIVE;
                            cnt_d[i]   = '0;
                            clean_d[i] = 1'b1;
                            rise_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                    ACTIVE: begin
                        if (!s_q[i]) begin
                            state_d[i] = REL;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                    REL: begin
                        if (s_q[i]) begin
                            state_d[i] = ACTIVE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                            clean_d[i] = 1'b0;
                            fall_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s_q     <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q    <= sensor_raw;
            s_q     <= s1_q;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign sensor_clean = clean_q;
    assign sensor_rise  = rise_q;
    assign sensor_fall  = fall_q;
    assign any_active   = |clean_q;

`ifdef SENSOR_LATCH_EN
    logic [N_CH-1:0] latch_q;

    // Set is taken from the registered strobe so a clear sampled alongside it loses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_q <= '0;
        end else begin
            latch_q <= rise_q | (latch_q & ~clr_latch);
        end
    end

    assign evt_latch = latch_q;
`else
    logic unused_clr;
    assign unused_clr = ^clr_latch;
    assign evt_latch  = '0;
`endif

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

- Per-channel input conditioner for the 8 sensor lines of the alarm design; sits between the `ui_in` pads and the buzzer state machine.
- Each channel:
  - synchronises its raw sensor bit with two flops;
  - qualifies level changes with a debounce counter and a 4-state FSM;
  - emits a clean level plus one-cycle rise and fall strobes.
- Optional sticky event latches let the downstream stage catch short qualified events.

## Interface
Parameters:
- `N_CH`, 8: number of sensor channels.
- `DEB_CYCLES`, 4: consecutive synchronised samples required to accept a level change. Legal range is 2..255. Counter width is `$clog2(DEB_CYCLES+1)`.

Ports:
- `clk`  in  1  system clock; every flop is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ena`  in  1  enable. Low means FSMs and counters hold, and strobes are forced to 0. Synchronisers keep running.
- `sensor_raw`  in  N_CH  raw, asynchronous sensor inputs from `ui_in`.
- `clr_latch`  in  N_CH  per-channel clear for `evt_latch`.
- `sensor_clean`  out  N_CH  debounced level, registered.
- `sensor_rise`  out  N_CH  one-cycle strobe when `sensor_clean` goes 0->1, registered.
- `sensor_fall`  out  N_CH  one-cycle strobe when `sensor_clean` goes 1->0, registered.
- `any_active`  out  1  OR-reduction of `sensor_clean`.
- `evt_latch`  out  N_CH  sticky record of rise events; see Configuration.

## Operation
- Synchroniser: `raw -> s1 -> s`. FSM logic uses `s` only.
- States per channel, with counter `cnt`:
  - **IDLE** (clean=0):
    - s=1: go to QUAL, cnt=1.
  - **QUAL** (clean=0):
    - s=0: return to IDLE, cnt=0.
    - else if cnt==DEB_CYCLES-1: go to ACTIVE, set clean=1, pulse rise.
    - else cnt++.
  - **ACTIVE** (clean=1):
    - s=0: go to REL, cnt=1.
  - **REL** (clean=1):
    - s=1: return to ACTIVE, cnt=0.
    - else if cnt==DEB_CYCLES-1: go to IDLE, set clean=0, pulse fall.
    - else cnt++.
- A glitch shorter than DEB_CYCLES synchronised samples never changes `sensor_clean`. The counter restarts on every opposite sample and never wraps.
- Channels are fully independent. Simultaneous changes on any subset of channels are each qualified separately.
- `ena`=0 mid-qualification freezes state and cnt. Counting resumes from the held value when `ena` returns to 1.
- Reset (asserted at any time):
  - every FSM goes to IDLE;
  - cnt, s1, s and all outputs go to 0.
  - `any_active`=0 immediately.
  - No fall strobe is generated for channels that were ACTIVE when reset hit.

## Timing
- Raw high is first sampled at edge k and stays stable:
  - `s`=1 after edge k+1;
  - `sensor_clean` and `sensor_rise` go high after edge k+DEB_CYCLES+1;
  - `sensor_rise` drops after the next edge.
- Release is symmetric: `sensor_clean`=0 and `sensor_fall`=1 after edge k+DEB_CYCLES+1.
- Rise and fall strobes are each exactly one cycle, and never both high on the same channel.
- `any_active` is combinational from the `sensor_clean` registers, so it has no extra latency.

## Configuration
Macro: `SENSOR_LATCH_EN`.
- Defined:
  - `evt_latch[i]` sets on the cycle `sensor_rise[i]` is high;
  - it clears on the edge after `clr_latch[i]`=1 is sampled;
  - if set and clear happen in the same cycle, set wins;
  - the latch ignores `ena`, and reset clears it.
- Undefined: `evt_latch` is tied to 0, `clr_latch` is unused, and no latch flops are synthesised.

## Test plan
All scenarios use DEB_CYCLES=4 and a 10 ns clock.
- **Reset:** `rst_n`=0 with `sensor_raw`=8'hFF -> all outputs 0. Releasing reset with raw held at 8'hFF -> `sensor_clean`=8'hFF five edges later, with a single-cycle `sensor_rise`=8'hFF.
- **Single channel:** raw[0] high for 100 ns -> `sensor_clean[0]` high 5 cycles after first sample. Raw[0] low -> `sensor_fall[0]` single pulse 5 cycles later. `any_active` tracks `sensor_clean[0]`.
- **Glitch reject:** raw[1] high for 3 cycles, low 1 cycle, high 3 cycles -> `sensor_clean[1]` stays 0 and no strobes.
- **Concurrent channels:** raw[2] and raw[1] raised on the same cycle and held 400 ns -> both clean bits and both rise strobes assert on the same cycle. Release of both -> simultaneous fall strobes.
- **Enable freeze:** raise raw[3], drop `ena` after 2 qualifying samples for 5 cycles, then restore `ena` -> clean asserts 2 cycles after `ena` returns, with no strobe while `ena`=0.
- **Latch (`SENSOR_LATCH_EN`):** rise on ch4 -> `evt_latch[4]`=1 and stays after raw drops. `clr_latch[4]` pulsed on the same cycle as a new rise -> latch stays 1. A later lone clear -> latch 0.
